// File: rtl/comp2_bist.sv
// Built-in self-test engine for the comp2 magnitude comparator: it sweeps every (a, b) pair,
// checks x/y/z against a golden compare, and reports the error count and the first failing vector.
module comp2_bist #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    input  logic                 x,
    input  logic                 y,
    input  logic                 z,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_cnt,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b
);

    localparam int IW = 2 * WIDTH;
    localparam int EW = 2 * WIDTH + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [EW-1:0] ERR_ONE  = EW'(1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_d, b_d, fail_a_d, fail_b_d;
    logic              busy_d, done_d, pass_d;
    logic [EW-1:0]     err_cnt_d;
    logic [2:0]        exp_xyz;
    logic              mismatch;
    logic              last_vec;

    // Golden response: exactly one of {a>b, a==b, a<b}; any other pattern is an error.
    always_comb begin
        exp_xyz  = {a > b, a == b, a < b};
        mismatch = (state_q == SAMPLE) && ({x, y, z} != exp_xyz);
        last_vec = &idx_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = DRIVE;
            DRIVE:      if (cnt_q == CNT_LAST) state_d = SAMPLE;
            SAMPLE:     state_d = last_vec ? DONE : DRIVE;
            default:    state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs and the sweep counters.
    always_comb begin
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        a_d       = a;
        b_d       = b;
        busy_d    = busy;
        done_d    = done;
        pass_d    = pass;
        err_cnt_d = err_cnt;
        fail_a_d  = fail_a;
        fail_b_d  = fail_b;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    idx_d     = '0;
                    cnt_d     = '0;
                    a_d       = '0;
                    b_d       = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    err_cnt_d = '0;
                    fail_a_d  = '0;
                    fail_b_d  = '0;
                end
            end
            DRIVE: begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_cnt_d = err_cnt + ERR_ONE;
                    if (err_cnt == '0) begin
                        fail_a_d = a;
                        fail_b_d = b;
                    end
                end
                if (last_vec) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (err_cnt_d == '0);
                    a_d    = '0;
                    b_d    = '0;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                    a_d   = idx_d[IW-1:WIDTH];
                    b_d   = idx_d[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            a       <= '0;
            b       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
            fail_a  <= '0;
            fail_b  <= '0;
        end else begin
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a       <= a_d;
            b       <= b_d;
            busy    <= busy_d;
            done    <= done_d;
            pass    <= pass_d;
            err_cnt <= err_cnt_d;
            fail_a  <= fail_a_d;
            fail_b  <= fail_b_d;
        end
    end

endmodule
